// File: rtl/debug_panel.sv
// Front-panel controller: debounced keys load a switch register, scroll a watch-word
// view, and drive a run/stop/single-step machine that emits a one-cycle CPU step enable.

module debug_key #(
  parameter int DEBOUNCE = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          s1, s2, db;
  logic [CW-1:0] cnt;

  // db is the accepted (active-low) level; it flips only after DEBOUNCE differing samples
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      db    <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt   <= '0;
        db    <= s2;
        press <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module debug_panel #(
  parameter int WORDS     = 32,
  parameter int SW_BYTES  = 2,
  parameter int DEBOUNCE  = 250000,
  parameter int DIV_WIDTH = 26
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [3:0]                 keys_n,
  input  logic [7:0]                 data_in,
  input  logic [1:0]                 byte_sel,
  input  logic                       run,
  input  logic [1:0]                 speed,
  input  logic                       halt,
  input  logic [WORDS*16-1:0]        watch,
  output logic [SW_BYTES*8-1:0]      switch_register,
  output logic                       cpu_step,
  output logic [1:0]                 state,
  output logic                       halted,
  output logic [$clog2(WORDS)-1:0]   view_index,
  output logic [15:0]                view_word,
  output logic                       active
);
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {STOPPED = 2'd0, RUNNING = 2'd1, STEP = 2'd2} state_t;

  logic [3:0]                 press;
  logic [SW_BYTES-1:0][7:0]   sw;
  logic [15:0]                words [WORDS];
  logic [DIV_WIDTH-1:0]       div;
  logic [1:0]                 speed_q;
  logic                       run_q, run_rise, tick;
  logic                       step_d, halted_d;
  state_t                     state_q, state_d;

  debug_key #(.DEBOUNCE(DEBOUNCE)) u_key [3:0] (
    .clock  (clock),
    .resetn (resetn),
    .key_n  (keys_n),
    .press  (press)
  );

  for (genvar i = 0; i < WORDS; i++) begin : g_word
    assign words[i] = watch[16*i +: 16];
  end

  assign switch_register = sw;
  assign active          = |sw;
  assign state           = state_q;
  assign run_rise        = run & ~run_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw         <= '0;
      view_index <= '0;
      view_word  <= '0;
    end else begin
      for (int b = 0; b < SW_BYTES; b++)
        if (press[0] && byte_sel == 2'(b)) sw[b] <= data_in;
      if (press[2] && !press[3])
        view_index <= (view_index == IW'(WORDS - 1)) ? '0 : view_index + 1'b1;
      else if (press[3] && !press[2])
        view_index <= (view_index == '0) ? IW'(WORDS - 1) : view_index - 1'b1;
      view_word <= words[view_index];
    end
  end

  // A speed change restarts the divider, so the new period is measured from the change
  always_comb begin
    tick = 1'b0;
    case (speed)
      2'd0:    tick = 1'b1;
      2'd1:    tick = &div[DIV_WIDTH-3:0];
      2'd2:    tick = &div[DIV_WIDTH-2:0];
      default: tick = &div;
    endcase
    if (speed != 2'd0 && speed != speed_q) tick = 1'b0;
  end

  // run_q resets high so a run level held through reset is not taken as an edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div      <= '0;
      speed_q  <= 2'd0;
      run_q    <= 1'b1;
      cpu_step <= 1'b0;
      halted   <= 1'b0;
    end else begin
      div      <= (speed != speed_q) ? '0 : div + 1'b1;
      speed_q  <= speed;
      run_q    <= run;
      cpu_step <= step_d;
      halted   <= halted_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= STOPPED;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: begin
        if (run_rise && !halt) state_d = RUNNING;
        else if (press[1])     state_d = STEP;
      end
      RUNNING: if (halt || !run) state_d = STOPPED;
      default: state_d = STOPPED;
    endcase
  end

  always_comb begin
    step_d   = 1'b0;
    halted_d = halted;
    case (state_q)
      STOPPED: begin
        if (halt)          halted_d = 1'b1;
        else if (run_rise) halted_d = 1'b0;
        step_d = press[1] && !(run_rise && !halt);
      end
      RUNNING: begin
        if (halt) halted_d = 1'b1;
        else      step_d   = run & tick;
      end
      default: ;
    endcase
  end
endmodule
